// File: rtl/his_peak_finder_if.sv
// rtl/his_peak_finder_if.sv - start/read/result bundle shared by peak finder and its neighbours
interface his_peak_finder_if #(
  parameter int ADDR_W = 6,
  parameter int BIN_W  = 8
);
  logic                    start;
  logic                    bank_sel;
  logic                    rd_en;
  logic                    rd_bank;
  logic [ADDR_W-1:0]       rd_addr;
  logic [BIN_W-1:0]        rd_data;
  logic                    peak_valid;
  logic                    peak_ready;
  logic [ADDR_W-1:0]       peak_bin;
  logic [BIN_W-1:0]        peak_count;
  logic [BIN_W+ADDR_W-1:0] total_count;
  logic                    no_target;
  logic                    busy;
  logic                    start_miss;

  modport master (
    output start, bank_sel, rd_data, peak_ready,
    input  rd_en, rd_bank, rd_addr, peak_valid, peak_bin, peak_count,
           total_count, no_target, busy, start_miss
  );

  modport slave (
    input  start, bank_sel, rd_data, peak_ready,
    output rd_en, rd_bank, rd_addr, peak_valid, peak_bin, peak_count,
           total_count, no_target, busy, start_miss
  );
endinterface

// File: rtl/his_peak_finder.sv
// rtl/his_peak_finder.sv - scans one histogram bank and reports max bin, its count and the bin sum
module his_peak_finder #(
  parameter int BIN_NUM = 64,
  parameter int BIN_W   = 8,
  parameter int ADDR_W  = 6,
  parameter int MIN_CNT = 3
) (
  input logic              clk,
  input logic              res,
  his_peak_finder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, REPORT} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BIN_NUM - 1);
  localparam logic [BIN_W:0]    MIN_CNT_V = (BIN_W + 1)'(MIN_CNT);

  state_t                  state;
  state_t                  state_next;
  logic                    rd_en_q;
  logic                    rd_bank_q;
  logic [ADDR_W-1:0]       rd_addr_q;
  logic                    beat_valid;
  logic [ADDR_W-1:0]       beat_addr;
  logic [BIN_W-1:0]        max_q;
  logic [ADDR_W-1:0]       idx_q;
  logic [BIN_W+ADDR_W-1:0] sum_q;
  logic                    no_target_q;
  logic                    peak_valid_q;
  logic                    busy_q;
  logic                    start_miss_q;
  logic                    beat_wins;
  logic [BIN_W-1:0]        max_next;

  always_ff @(posedge clk or posedge res) begin
    if (res) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SCAN;
      SCAN:    if (rd_addr_q == LAST_ADDR) state_next = DRAIN;
      DRAIN:   state_next = REPORT;
      REPORT:  if (bus.peak_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strictly-greater update over an ascending scan keeps the lowest index on ties.
  always_comb begin
    beat_wins = beat_valid && (bus.rd_data > max_q);
    max_next  = beat_wins ? bus.rd_data : max_q;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      rd_en_q      <= 1'b0;
      rd_bank_q    <= 1'b0;
      rd_addr_q    <= '0;
      beat_valid   <= 1'b0;
      beat_addr    <= '0;
      max_q        <= '0;
      idx_q        <= '0;
      sum_q        <= '0;
      no_target_q  <= 1'b0;
      peak_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      start_miss_q <= 1'b0;
    end else begin
      rd_en_q      <= (state_next == SCAN);
      peak_valid_q <= (state_next == REPORT);
      busy_q       <= (state_next != IDLE);
      start_miss_q <= bus.start && (state != IDLE);
      beat_valid   <= rd_en_q;
      beat_addr    <= rd_addr_q;

      if (state == IDLE && bus.start) begin
        rd_bank_q   <= bus.bank_sel;
        rd_addr_q   <= '0;
        max_q       <= '0;
        idx_q       <= '0;
        sum_q       <= '0;
        no_target_q <= 1'b0;
      end else begin
        if (state == SCAN && rd_addr_q != LAST_ADDR)
          rd_addr_q <= rd_addr_q + ADDR_W'(1);
        if (beat_valid) begin
          sum_q <= sum_q + {{ADDR_W{1'b0}}, bus.rd_data};
          max_q <= max_next;
          if (beat_wins) idx_q <= beat_addr;
        end
        // DRAIN sees the last beat, so the threshold uses the post-beat maximum.
        if (state == DRAIN)
          no_target_q <= ({1'b0, max_next} < MIN_CNT_V);
      end
    end
  end

  assign bus.rd_en       = rd_en_q;
  assign bus.rd_bank     = rd_bank_q;
  assign bus.rd_addr     = rd_addr_q;
  assign bus.peak_valid  = peak_valid_q;
  assign bus.peak_bin    = idx_q;
  assign bus.peak_count  = max_q;
  assign bus.total_count = sum_q;
  assign bus.no_target   = no_target_q;
  assign bus.busy        = busy_q;
  assign bus.start_miss  = start_miss_q;
endmodule

// File: tb/tb_his_peak_finder.sv
// tb/tb_his_peak_finder.sv - randomized and directed checks of his_peak_finder against a timeline model
module tb_his_peak_finder;
  localparam int N  = 8;
  localparam int BW = 4;
  localparam int AW = 3;
  localparam int MC = 3;

  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;

  his_peak_finder_if #(.ADDR_W(AW), .BIN_W(BW)) bus ();

  his_peak_finder #(.BIN_NUM(N), .BIN_W(BW), .ADDR_W(AW), .MIN_CNT(MC)) dut (
    .clk(clk),
    .res(res),
    .bus(bus)
  );

  logic [BW-1:0] mem [2][N];
  int n_checks = 0;
  int n_fail   = 0;
  int miss_total = 0;

  int m_phase = -1;
  int m_addr  = 0;
  int m_bank  = 0;
  int m_miss  = 0;
  int e_bin, e_cnt, e_sum, e_nt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compute(input int b);
    e_cnt = 0; e_bin = 0; e_sum = 0;
    for (int i = 0; i < N; i++) begin
      e_sum += int'(mem[b][i]);
      if (int'(mem[b][i]) > e_cnt) begin
        e_cnt = int'(mem[b][i]);
        e_bin = i;
      end
    end
    e_nt = (e_cnt < MC) ? 1 : 0;
  endtask

  // Histogram RAM: data for a read appears one cycle after rd_en, noise otherwise.
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_bank][bus.rd_addr];
    else           bus.rd_data <= BW'($urandom);
  end

  // Timeline model: m_phase counts edges since the accepted start, -1 when idle.
  always @(posedge clk or posedge res) begin
    if (res) begin
      m_phase = -1; m_addr = 0; m_bank = 0; m_miss = 0;
    end else begin
      m_miss = (bus.start && m_phase != -1) ? 1 : 0;
      if (m_phase == -1) begin
        if (bus.start) begin
          m_phase = 0;
          m_addr  = 0;
          m_bank  = int'(bus.bank_sel);
          compute(m_bank);
        end
      end else if (m_phase >= N + 1 && bus.peak_ready) begin
        m_phase = -1;
      end else begin
        m_phase++;
        if (m_phase <= N - 1) m_addr = m_phase;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", bus.busy, (m_phase >= 0));
    check("rd_en", bus.rd_en, (m_phase >= 0 && m_phase <= N - 1));
    check("rd_addr", bus.rd_addr, m_addr);
    check("rd_bank", bus.rd_bank, m_bank);
    check("peak_valid", bus.peak_valid, (m_phase >= N + 1));
    check("start_miss", bus.start_miss, m_miss);
    if (bus.start_miss === 1'b1) miss_total++;
    if (m_phase >= N + 1) begin
      check("peak_bin", bus.peak_bin, e_bin);
      check("peak_count", bus.peak_count, e_cnt);
      check("total_count", bus.total_count, e_sum);
      check("no_target", bus.no_target, e_nt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int b);
    bus.start    = 1'b1;
    bus.bank_sel = b[0];
    step();
    bus.start    = 1'b0;
  endtask

  // Starts a frame and returns at the first negedge showing peak_valid; c counts negedges.
  task automatic run_frame(input int b, output int c);
    pulse_start(b);
    c = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      c++;
      if (bus.peak_valid) return;
    end
    check("wait_peak_valid_timeout", 0, 1);
  endtask

  task automatic load(input int b, input int v0, input int v1, input int v2, input int v3,
                      input int v4, input int v5, input int v6, input int v7);
    mem[b][0] = BW'(v0); mem[b][1] = BW'(v1); mem[b][2] = BW'(v2); mem[b][3] = BW'(v3);
    mem[b][4] = BW'(v4); mem[b][5] = BW'(v5); mem[b][6] = BW'(v6); mem[b][7] = BW'(v7);
  endtask

  task automatic expect_result(input string tag, input int bin, input int cnt, input int sum, input int nt);
    check({tag, "_model_bin"}, e_bin, bin);
    check({tag, "_model_cnt"}, e_cnt, cnt);
    check({tag, "_model_sum"}, e_sum, sum);
    check({tag, "_peak_bin"}, bus.peak_bin, bin);
    check({tag, "_peak_count"}, bus.peak_count, cnt);
    check({tag, "_total_count"}, bus.total_count, sum);
    check({tag, "_no_target"}, bus.no_target, nt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int miss0;
    int guard;
    bus.start = 1'b0; bus.bank_sel = 1'b0; bus.peak_ready = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < N; i++) mem[b][i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en", bus.rd_en, 0);
    check("rst_peak_valid", bus.peak_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    check("rst_peak_count", bus.peak_count, 0);
    check("rst_total_count", bus.total_count, 0);
    res = 1'b0;
    step();

    bus.peak_ready = 1'b1;
    load(1, 0, 2, 9, 1, 9, 0, 3, 1);
    run_frame(1, c);
    check("basic_valid_edge", c, N + 2);
    expect_result("basic", 2, 9, 25, 0);
    step();

    load(0, 15, 15, 15, 15, 15, 15, 15, 15);
    run_frame(0, c);
    expect_result("full", 0, 15, 120, 0);
    step();

    load(1, 0, 0, 0, 0, 2, 0, 0, 0);
    run_frame(1, c);
    expect_result("low", 4, 2, 2, 1);
    step();

    load(0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_frame(0, c);
    expect_result("zero", 0, 0, 0, 1);
    step();

    // Consumer stalls 20 cycles; a start during REPORT must only pulse start_miss.
    bus.peak_ready = 1'b0;
    load(0, 3, 7, 1, 7, 0, 5, 2, 6);
    run_frame(0, c);
    miss0 = miss_total;
    for (int i = 0; i < 20; i++) begin
      bus.start = (i == 10);
      step();
      @(negedge clk);
    end
    bus.start = 1'b0;
    expect_result("stall", 1, 7, 31, 0);
    bus.peak_ready = 1'b1;
    step();
    @(negedge clk);
    check("stall_back_idle", bus.busy, 0);
    check("stall_miss_once", miss_total - miss0, 1);

    // Reset mid-scan, then a clean frame from address 0.
    load(1, 0, 2, 9, 1, 9, 0, 3, 1);
    pulse_start(1);
    guard = 0;
    while (m_phase != 5 && guard < 50) begin step(); guard++; end
    check("reset_reach_addr5", bus.rd_addr, 5);
    res = 1'b1;
    @(negedge clk);
    check("abort_rd_en", bus.rd_en, 0);
    check("abort_rd_addr", bus.rd_addr, 0);
    check("abort_rd_bank", bus.rd_bank, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_peak_bin", bus.peak_bin, 0);
    check("abort_total", bus.total_count, 0);
    step();
    res = 1'b0;
    step(); step();
    check("abort_wait_idle", bus.busy, 0);
    run_frame(1, c);
    check("rescan_valid_edge", c, N + 2);
    expect_result("rescan", 2, 9, 25, 0);

    // Back-to-back frames, next start one cycle after accept.
    load(0, 1, 4, 4, 0, 2, 8, 8, 3);
    load(1, 6, 0, 1, 6, 0, 0, 1, 2);
    step();
    miss0 = miss_total;
    run_frame(0, c);
    expect_result("b2b_a", 5, 8, 30, 0);
    step();
    run_frame(1, c);
    check("b2b_second_latency", c, N + 2);
    expect_result("b2b_b", 0, 6, 16, 0);
    step();
    check("b2b_no_miss", miss_total - miss0, 0);

    // Random frames, random backpressure, stray starts.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bus.peak_ready = ($urandom_range(0, 2) != 0);
      bus.start = 1'b0;
      if (m_phase == -1 && $urandom_range(0, 3) == 0) begin
        for (int b = 0; b < 2; b++)
          for (int i = 0; i < N; i++)
            mem[b][i] = $urandom_range(0, 1) ? BW'($urandom_range(0, 15)) : BW'($urandom_range(0, 2));
        bus.start = 1'b1;
        bus.bank_sel = 1'($urandom_range(0, 1));
      end else if ($urandom_range(0, 9) == 0) begin
        bus.start = 1'b1;
        bus.bank_sel = 1'($urandom_range(0, 1));
      end
      step();
    end
    bus.start = 1'b0;
    bus.peak_ready = 1'b1;
    repeat (N + 6) step();
    check("final_idle", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/his_peak_finder.md
HIS_PEAK_FINDER -- requirements
Module: his_peak_finder

Interface
REQ-001 Parameter BIN_NUM, default 64: bins per histogram, indexed 0..BIN_NUM-1; legal range 2..2^ADDR_W.
REQ-002 Parameter BIN_W, default 8: width of one bin count.
REQ-003 Parameter ADDR_W, default 6: bin address width, equal to clog2(BIN_NUM).
REQ-004 Parameter MIN_CNT, default 3: minimum peak count for a valid target.
REQ-005 Port clk, input, 1: single clock; all logic rising-edge.
REQ-006 Port res, input, 1: reset; asynchronous, active-high.
REQ-007 Port start, input, 1: one-cycle pulse from the histogram builder; a histogram bank is complete.
REQ-008 Port bank_sel, input, 1: bank to scan; sampled with start.
REQ-009 Port rd_en, output, 1: histogram RAM read strobe.
REQ-010 Port rd_bank, output, 1: bank being read; equals the latched bank_sel.
REQ-011 Port rd_addr, output, ADDR_W: bin address being read.
REQ-012 Port rd_data, input, BIN_W: bin count; valid exactly one cycle after rd_en.
REQ-013 Port peak_valid, output, 1: result available.
REQ-014 Port peak_ready, input, 1: consumer accepts the result.
REQ-015 Port peak_bin, output, ADDR_W: index of the maximum bin.
REQ-016 Port peak_count, output, BIN_W: count in the maximum bin.
REQ-017 Port total_count, output, BIN_W+ADDR_W: sum of all bin counts.
REQ-018 Port no_target, output, 1: peak_count < MIN_CNT; valid with peak_valid.
REQ-019 Port busy, output, 1: high in every state except IDLE.
REQ-020 Port start_miss, output, 1: one-cycle pulse when start arrives while busy.

Function
REQ-021 FSM states: IDLE, SCAN, DRAIN, REPORT.
REQ-022 IDLE: when start=1, latch bank_sel, clear max/index/sum accumulators, and go to SCAN.
REQ-023 SCAN: assert rd_en for exactly BIN_NUM consecutive cycles, with rd_addr = 0,1,..,BIN_NUM-1; after the last address, go to DRAIN.
REQ-024 DRAIN: one cycle, rd_en=0; capture the final rd_data, then go to REPORT.
REQ-025 Every rd_data beat is added to the sum; width BIN_W+ADDR_W, never overflows; no saturation logic.
REQ-026 A beat replaces the running maximum only if it is strictly greater; ties keep the lowest bin index.
REQ-027 An all-zero histogram yields peak_bin=0, peak_count=0, total_count=0, no_target=1.
REQ-028 REPORT: peak_valid=1; peak_bin, peak_count, total_count and no_target are held stable until peak_ready=1.
REQ-029 Transfer completes on a cycle with peak_valid=1 and peak_ready=1; the next state is IDLE and peak_valid drops.
REQ-030 Latency: start sampled at edge 0 gives rd_en high at edges 1..BIN_NUM and peak_valid high from edge BIN_NUM+2.
REQ-031 start in SCAN, DRAIN or REPORT is ignored, does not disturb the scan, and pulses start_miss for one cycle.
REQ-032 start coinciding with the REPORT accept cycle is a miss; the FSM returns to IDLE.
REQ-033 rd_addr holds its last value when rd_en=0; rd_bank is stable from start through REPORT.
REQ-034 Outputs are registered; rd_data feeds no output combinationally.

Reset
REQ-035 Reset values: state=IDLE; rd_en, peak_valid, busy, start_miss and no_target = 0; rd_addr, rd_bank, peak_bin, peak_count and total_count = 0.
REQ-036 res asserted mid-SCAN or mid-REPORT aborts immediately; the pending result is discarded; after release the block waits in IDLE for a new start.

Verification
REQ-037 BIN_NUM=8, BIN_W=4, bank_sel=1, counts {0,2,9,1,9,0,3,1} -> rd_addr 0..7 at edges 1..8 with rd_bank=1; peak_bin=2, peak_count=9, total_count=25, no_target=0, peak_valid at edge 10.
REQ-038 All bins=15 -> peak_bin=0, peak_count=15, total_count=120 (no overflow).
REQ-039 Counts {0,0,0,0,2,0,0,0}, MIN_CNT=3 -> peak_bin=4, peak_count=2, no_target=1.
REQ-040 peak_ready held low 20 cycles, then start pulsed during REPORT -> outputs stable throughout, start_miss pulses once, result accepted on the first ready cycle, then IDLE.
REQ-041 res pulsed at SCAN address 5 -> all outputs at reset values; a following start gives a correct full scan from address 0.
REQ-042 Two back-to-back frames with ready tied high and start one cycle after the accept -> both results correct with no start_miss.
